// File: rtl/sap1_output_display.sv
// SAP-1 output display: captures the output register value, converts it to
// three BCD digits with a sequential double-dabble (one step per clock), and
// time-multiplexes hundreds/tens/ones onto a single 7-segment bus.
// The committed result (bcd_out) drives the display, so the previous value
// stays visible while a new conversion runs.
module sap1_output_display #(
  parameter int unsigned DWELL = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  data_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        busy,
  output logic [11:0] bcd_out
);

  localparam int unsigned DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned SW         = 3;
  localparam int unsigned BW         = 12;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(7);

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [7:0]      shift_q, shift_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [SW-1:0]   step_q, step_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            blank_q, blank_d;
  logic [6:0]      seg_d;
  logic            dp_d;
  logic [1:0]      sel_d;
  logic            busy_d;
  logic [BW-1:0]   bcd_d;
  logic            restart;
  logic [BW-1:0]   adj;
  logic [BW+7:0]   shifted;

  // Add 3 to any BCD nibble of 5 or more before the shift
  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction

  // Active-high segment pattern for a decimal digit (a = bit 0)
  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h00;
    endcase
    return c;
  endfunction

  // One double-dabble step on the current scratch/shift pair
  always_comb begin
    adj     = {dabble(scratch_q[11:8]), dabble(scratch_q[7:4]), dabble(scratch_q[3:0])};
    shifted = {adj[BW-2:0], shift_q, 1'b0};
  end

  // Conversion FSM next state and datapath updates
  always_comb begin
    state_next = state;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    step_d     = step_q;
    bcd_d      = bcd_out;
    blank_d    = blank_q;
    restart    = 1'b0;

    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      CONVERT: begin
        scratch_d = shifted[BW+7:8];
        shift_d   = shifted[7:0];
        if (step_q == STEP_LAST) begin
          bcd_d      = shifted[BW+7:8];
          blank_d    = 1'b0;
          restart    = 1'b1;
          state_next = IDLE;
        end else begin
          step_d = SW'(step_q + 1'b1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A load always (re)starts; on the final step the commit above still lands
    if (load) begin
      shift_d    = data_in;
      scratch_d  = '0;
      step_d     = '0;
      state_next = CONVERT;
    end

    busy_d = (state_next == CONVERT);
  end

  // Display slot sequencer; a fresh commit restarts at the hundreds slot
  always_comb begin
    dwell_d = dwell_q;
    sel_d   = digit_sel;
    if (restart) begin
      dwell_d = '0;
      sel_d   = 2'd0;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      sel_d   = 2'(digit_sel + 1'b1);
    end else begin
      dwell_d = DW'(dwell_q + 1'b1);
    end
  end

  // Segment decode for the slot that becomes current on the next edge
  always_comb begin
    seg_d = 7'h00;
    dp_d  = 1'b0;
    if (!blank_d) begin
      case (sel_d)
        2'd0: seg_d = (bcd_d[11:8] == 4'd0) ? 7'h00 : seg_code(bcd_d[11:8]);
        2'd1: seg_d = (bcd_d[11:4] == 8'd0) ? 7'h00 : seg_code(bcd_d[7:4]);
        2'd2: begin
          seg_d = seg_code(bcd_d[3:0]);
          dp_d  = 1'b1;
        end
        default: begin
          seg_d = 7'h00;
          dp_d  = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      scratch_q <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      blank_q   <= 1'b1;
      bcd_out   <= '0;
      busy      <= 1'b0;
      digit_sel <= 2'd0;
      seg       <= 7'h00;
      dp        <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      blank_q   <= blank_d;
      bcd_out   <= bcd_d;
      busy      <= busy_d;
      digit_sel <= sel_d;
      seg       <= seg_d;
      dp        <= dp_d;
    end
  end

endmodule

// File: tb/tb_sap1_output_display.sv
// Randomized and directed bench for sap1_output_display against a
// value-level reference model (decimal arithmetic, cycle countdown).
module tb_sap1_output_display;

  localparam int unsigned DWELL = 3;

  logic        clk;
  logic        rst;
  logic        load;
  logic [7:0]  data_in;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        busy;
  logic [11:0] bcd_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_rem   = 0;
  logic [7:0]  m_pend  = '0;
  logic [11:0] m_bcd   = '0;
  bit          m_blank = 1'b1;
  int          m_k     = 0;

  logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  sap1_output_display #(.DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel),
    .busy      (busy),
    .bcd_out   (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int unsigned x;
    x = v;
    return {4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // Advance the model by one clock edge with the inputs seen at that edge
  task automatic model_edge(input logic r, input logic l, input logic [7:0] d);
    if (r) begin
      m_rem = 0; m_bcd = '0; m_blank = 1'b1; m_k = 0;
    end else begin
      if (m_rem == 1) begin
        m_bcd = to_bcd(m_pend); m_blank = 1'b0; m_k = 0;
      end else begin
        m_k = (m_k + 1) % (4 * DWELL);
      end
      if (l) begin
        m_pend = d; m_rem = 8;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
  endtask

  task automatic compare_all();
    int sel;
    logic [6:0] e_seg;
    logic e_dp;
    sel   = (m_k / DWELL) % 4;
    e_seg = 7'h00;
    e_dp  = 1'b0;
    if (!m_blank) begin
      case (sel)
        0: e_seg = (m_bcd[11:8] == 0) ? 7'h00 : lut[m_bcd[11:8]];
        1: e_seg = (m_bcd[11:4] == 0) ? 7'h00 : lut[m_bcd[7:4]];
        2: begin e_seg = lut[m_bcd[3:0]]; e_dp = 1'b1; end
        default: e_seg = 7'h00;
      endcase
    end
    check("busy", 32'(busy), 32'(m_rem > 0));
    check("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check("digit_sel", 32'(digit_sel), 32'(sel));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic tick(input logic r, input logic l, input logic [7:0] d);
    rst = r; load = l; data_in = d;
    @(posedge clk);
    model_edge(r, l, d);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = 8'h00;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    check("reset_bcd", 32'(bcd_out), 32'h000);
    check("reset_sel", 32'(digit_sel), 32'd0);
    idle(30);

    // Full-scale value
    tick(1'b0, 1'b1, 8'hFF);
    idle(8);
    check("bcd_255", 32'(bcd_out), 32'h255);
    check("seg_h2", 32'(seg), 32'h5B);
    idle(12);

    // Leading-zero blanking cases
    tick(1'b0, 1'b1, 8'h07);  idle(20);
    tick(1'b0, 1'b1, 8'h00);  idle(20);
    tick(1'b0, 1'b1, 8'h64);  idle(8);
    check("bcd_100", 32'(bcd_out), 32'h100);
    idle(12);

    // Abort at E4 while 255 is on display
    tick(1'b0, 1'b1, 8'hFF);  idle(20);
    tick(1'b0, 1'b1, 8'hC8);  idle(3);
    tick(1'b0, 1'b1, 8'h2A);  idle(7);
    check("abort_hold", 32'(bcd_out), 32'h255);
    idle(1);
    check("bcd_042", 32'(bcd_out), 32'h042);
    idle(12);

    // Reset wins over load; reset mid-conversion
    tick(1'b1, 1'b1, 8'h99);
    check("rst_load_busy", 32'(busy), 32'd0);
    idle(5);
    tick(1'b0, 1'b1, 8'hAB);  idle(4);
    tick(1'b1, 1'b0, 8'h00);
    check("rst_mid_bcd", 32'(bcd_out), 32'h000);
    idle(15);

    // Load on the commit edge
    tick(1'b0, 1'b1, 8'h37);  idle(7);
    tick(1'b0, 1'b1, 8'h80);
    check("e8_commit", 32'(bcd_out), 32'h055);
    check("e8_busy", 32'(busy), 32'd1);
    idle(8);
    check("bcd_128", 32'(bcd_out), 32'h128);
    idle(10);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      tick(1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 11) == 0),
           8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
